// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-4 registered demultiplexer: channel count,
// select width and default data/counter widths.
package demux_pkg;
    localparam int NCH      = 4;
    localparam int SELW     = 2;
    localparam int W_DEF    = 6;
    localparam int CNTW_DEF = 8;

    typedef logic [SELW-1:0] sel_t;
endpackage

// File: rtl/demux_fifo2.sv
// Two-entry registered FIFO used as the per-channel output queue.
// The head is read straight from the storage registers, so a word pushed into an empty queue is visible the next cycle.
module demux_fifo2 #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    logic [W-1:0] mem [2];
    logic         wp;
    logic         rp;
    logic [1:0]   cnt;
    logic         push_ok;
    logic         pop_ok;

    assign full    = (cnt == 2'd2);
    assign empty   = (cnt == 2'd0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rp];

    // Storage is cleared too so the head never shows X after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push_ok) begin
                mem[wp] <= din;
                wp      <= ~wp;
            end
            if (pop_ok) begin
                rp <= ~rp;
            end
            if (push_ok && !pop_ok) begin
                cnt <= cnt + 2'd1;
            end else if (pop_ok && !push_ok) begin
                cnt <= cnt - 2'd1;
            end
        end
    end
endmodule

// File: rtl/demux4_reg6.sv
// Routes each accepted input word to one of four 2-deep output queues and
// counts accepted words. Queue state lives in demux_fifo2.
module demux4_reg6
    import demux_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int CNTW = CNTW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      s,
    input  logic [W-1:0]    d,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      o_ready,
    output logic [3:0]      o_valid,
    output logic [W-1:0]    o0,
    output logic [W-1:0]    o1,
    output logic [W-1:0]    o2,
    output logic [W-1:0]    o3,
    output logic [CNTW-1:0] acc_cnt
);
    logic [NCH-1:0] full;
    logic [NCH-1:0] empty;
    logic [NCH-1:0] push;
    logic [NCH-1:0] pop;
    logic [W-1:0]   head [NCH];
    logic           accept;
    sel_t           sel;

    assign sel = s;

    // Ready looks only at the addressed queue, never at o_ready, so a full
    // queue stalls even when it is being drained in the same cycle.
    assign in_ready = ~full[sel];
    assign accept   = in_valid & in_ready;

    always_comb begin
        push = '0;
        if (accept) begin
            push[sel] = 1'b1;
        end
    end

    assign o_valid = ~empty;
    assign pop     = o_valid & o_ready;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        demux_fifo2 #(.W(W)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[i]),
            .pop   (pop[i]),
            .din   (d),
            .full  (full[i]),
            .empty (empty[i]),
            .head  (head[i])
        );
    end

    assign o0 = head[0];
    assign o1 = head[1];
    assign o2 = head[2];
    assign o3 = head[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_cnt <= '0;
        end else if (accept) begin
            acc_cnt <= acc_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_demux4_reg6.sv
// Bench for demux4_reg6: directed vector table, wrap/reset sequences and
// randomized traffic against a queue-based reference model.
module tb_demux4_reg6;
    localparam int W    = 6;
    localparam int CNTW = 8;

    logic            clk;
    logic            rst;
    logic [1:0]      s;
    logic [W-1:0]    d;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      o_ready;
    logic [3:0]      o_valid;
    logic [W-1:0]    o0, o1, o2, o3;
    logic [CNTW-1:0] acc_cnt;

    demux4_reg6 #(.W(W), .CNTW(CNTW)) dut (
        .clk      (clk),
        .rst      (rst),
        .s        (s),
        .d        (d),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .o_ready  (o_ready),
        .o_valid  (o_valid),
        .o0       (o0),
        .o1       (o1),
        .o2       (o2),
        .o3       (o3),
        .acc_cnt  (acc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    // Reference model: one queue per channel plus a modulo-256 accept count.
    logic [W-1:0]    q [4][$];
    logic [CNTW-1:0] macc;
    bit              model_ok = 0;

    typedef struct {
        logic       rst;
        logic       iv;
        logic [1:0] s;
        logic [5:0] d;
        logic [3:0] ordy;
        int         exp_ir;
        logic [3:0] exp_ov;
        logic [7:0] exp_acc;
        int         exp_ch;
        logic [5:0] exp_dat;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(logic iv, logic [1:0] ss, logic [5:0] dd, logic [3:0] ordy,
                                int ir, logic [3:0] ov, logic [7:0] acc, int ch, logic [5:0] dat);
        vec_t v;
        v.rst = 1'b0; v.iv = iv; v.s = ss; v.d = dd; v.ordy = ordy;
        v.exp_ir = ir; v.exp_ov = ov; v.exp_acc = acc; v.exp_ch = ch; v.exp_dat = dat;
        return v;
    endfunction

    function automatic logic [W-1:0] get_o(int i);
        case (i)
            0:       return o0;
            1:       return o1;
            2:       return o2;
            default: return o3;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, check in_ready mid-cycle, advance the
    // model at the edge, then check registered outputs 1 ns after it.
    task automatic do_cycle(input logic r, input logic iv_i, input logic [1:0] ss,
                            input logic [5:0] dd, input logic [3:0] ordy, input int exp_ir);
        bit           acc_ok;
        logic [W-1:0] tmp;
        rst = r; in_valid = iv_i; s = ss; d = dd; o_ready = ordy;
        #4;
        if (model_ok) chk("model_in_ready", {31'b0, in_ready}, {31'b0, q[ss].size() != 2});
        if (exp_ir >= 0) chk("tbl_in_ready", {31'b0, in_ready}, exp_ir);
        acc_ok = iv_i && (q[ss].size() < 2);
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 4; i++) q[i].delete();
            macc     = '0;
            model_ok = 1;
        end else if (model_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (q[i].size() > 0 && ordy[i]) tmp = q[i].pop_front();
            end
            if (acc_ok) begin
                q[ss].push_back(dd);
                macc = macc + 1'b1;
            end
        end
        #1;
        if (model_ok) begin
            chk("model_acc_cnt", {24'b0, acc_cnt}, {24'b0, macc});
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("model_o_valid%0d", i), {31'b0, o_valid[i]}, {31'b0, q[i].size() != 0});
                if (q[i].size() > 0)
                    chk($sformatf("model_o%0d", i), {26'b0, get_o(i)}, {26'b0, q[i][0]});
            end
        end
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_o_valid"}, {28'b0, o_valid}, 32'h0);
        chk({tag, "_acc_cnt"}, {24'b0, acc_cnt}, 32'h0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_o%0d", tag, i), {26'b0, get_o(i)}, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //           iv  s     d      ordy    ir  ov       acc  ch  dat
        tbl[0]  = mk(1, 2'd2, 6'h15, 4'b0000, 1, 4'b0100, 8'd1, 2, 6'h15);
        tbl[1]  = mk(1, 2'd1, 6'h01, 4'b0000, 1, 4'b0110, 8'd2, 1, 6'h01);
        tbl[2]  = mk(1, 2'd1, 6'h02, 4'b0000, 1, 4'b0110, 8'd3, 1, 6'h01);
        tbl[3]  = mk(1, 2'd1, 6'h03, 4'b0000, 0, 4'b0110, 8'd3, 1, 6'h01);
        tbl[4]  = mk(1, 2'd1, 6'h03, 4'b0010, 0, 4'b0110, 8'd3, 1, 6'h02);
        tbl[5]  = mk(1, 2'd1, 6'h03, 4'b0010, 1, 4'b0110, 8'd4, 1, 6'h03);
        tbl[6]  = mk(0, 2'd1, 6'h00, 4'b0010, 1, 4'b0100, 8'd4, -1, 6'h00);
        tbl[7]  = mk(0, 2'd0, 6'h00, 4'b0100, 1, 4'b0000, 8'd4, -1, 6'h00);
        tbl[8]  = mk(1, 2'd0, 6'h11, 4'b0000, 1, 4'b0001, 8'd5, 0, 6'h11);
        tbl[9]  = mk(1, 2'd0, 6'h12, 4'b0000, 1, 4'b0001, 8'd6, 0, 6'h11);
        tbl[10] = mk(1, 2'd0, 6'h13, 4'b0000, 0, 4'b0001, 8'd6, 0, 6'h11);
        tbl[11] = mk(1, 2'd3, 6'h3F, 4'b0000, 1, 4'b1001, 8'd7, 3, 6'h3F);
        tbl[12] = mk(0, 2'd0, 6'h00, 4'b1001, 0, 4'b0001, 8'd7, 0, 6'h12);
        tbl[13] = mk(0, 2'd0, 6'h00, 4'b0001, 1, 4'b0000, 8'd7, -1, 6'h00);
        tbl[14] = mk(1, 2'd0, 6'h0A, 4'b0000, 1, 4'b0001, 8'd8, 0, 6'h0A);
        tbl[15] = mk(1, 2'd0, 6'h0B, 4'b0001, 1, 4'b0001, 8'd9, 0, 6'h0B);
        tbl[16] = mk(0, 2'd0, 6'h00, 4'b0001, 1, 4'b0000, 8'd9, -1, 6'h00);

        // Two reset cycles with in_valid high: nothing may be accepted.
        do_cycle(1, 1, 2'd0, 6'h3F, 4'b0000, -1);
        do_cycle(1, 1, 2'd1, 6'h2A, 4'b1111, -1);
        chk_cleared("reset");

        for (int k = 0; k < 17; k++) begin
            do_cycle(tbl[k].rst, tbl[k].iv, tbl[k].s, tbl[k].d, tbl[k].ordy, tbl[k].exp_ir);
            chk($sformatf("tbl%0d_o_valid", k), {28'b0, o_valid}, {28'b0, tbl[k].exp_ov});
            chk($sformatf("tbl%0d_acc_cnt", k), {24'b0, acc_cnt}, {24'b0, tbl[k].exp_acc});
            if (tbl[k].exp_ch >= 0)
                chk($sformatf("tbl%0d_o%0d", k, tbl[k].exp_ch), {26'b0, get_o(tbl[k].exp_ch)},
                    {26'b0, tbl[k].exp_dat});
        end

        // 256 accepts from a cleared state wrap the counter back to zero.
        do_cycle(1, 0, 2'd0, 6'h00, 4'b0000, -1);
        for (int k = 0; k < 256; k++) begin
            logic [7:0] kk;
            kk = k[7:0];
            do_cycle(0, 1, kk[1:0], kk[5:0], 4'b1111, 1);
        end
        chk("wrap_acc_cnt", {24'b0, acc_cnt}, 32'h0);

        // Leave several channels occupied, then reset over an accept and pops.
        do_cycle(0, 1, 2'd0, 6'h2A, 4'b0000, 1);
        do_cycle(0, 1, 2'd2, 6'h15, 4'b0000, 1);
        chk("pre_rst_o_valid", {28'b0, o_valid}, 32'b1101);
        do_cycle(1, 1, 2'd1, 6'h3F, 4'b1111, -1);
        chk_cleared("midrst");
        do_cycle(0, 0, 2'd1, 6'h00, 4'b0000, 1);

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 600; k++) begin
            logic       r;
            logic       iv;
            logic [1:0] ss;
            logic [5:0] dd;
            logic [3:0] ordy;
            r    = ($urandom_range(0, 63) == 0);
            iv   = ($urandom_range(0, 3) != 0);
            ss   = 2'($urandom_range(0, 3));
            dd   = 6'($urandom_range(0, 63));
            ordy = 4'($urandom_range(0, 15));
            do_cycle(r, iv, ss, dd, ordy, -1);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/demux4_reg6.md
DEMUX4_REG6 -- requirements
Module: demux4_reg6

Interface
REQ-001 Parameter W, default 6, data width of the input and each output channel.
REQ-002 Parameter CNTW, default 8, width of the accepted-word counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 s  input  2  destination channel select for the current input word.
REQ-006 d  input  W  input data word.
REQ-007 in_valid  input  1  producer asserts when s/d are valid.
REQ-008 in_ready  output  1  block can accept the word addressed by s.
REQ-009 o_ready  input  4  per-channel consumer ready, bit i for channel i.
REQ-010 o_valid  output  4  per-channel data valid, bit i for channel i.
REQ-011 o0, o1, o2, o3  output  W each  per-channel head-of-queue data.
REQ-012 acc_cnt  output  CNTW  count of input words accepted since reset.

Function
REQ-013 Each channel i SHALL own a 2-entry FIFO with occupancy count 0, 1 or 2.
REQ-014 in_ready SHALL equal (count[s] != 2), combinational on s only; it SHALL NOT depend on o_ready.
REQ-015 Accept occurs when in_valid && in_ready; d SHALL be written to the tail of FIFO s on that edge.
REQ-016 o_valid[i] SHALL equal (count[i] != 0); oi SHALL present the FIFO i head entry from a register.
REQ-017 Pop occurs when o_valid[i] && o_ready[i]; the head SHALL advance on that edge.
REQ-018 Latency: a word accepted at edge N SHALL appear at its output by edge N (o_valid high in cycle N+1) if that FIFO was empty.
REQ-019 Push and pop on the same channel in the same cycle SHALL leave count unchanged and preserve FIFO order.
REQ-020 With count[s]==2, the input SHALL stall even if channel s pops in the same cycle.
REQ-021 Channels SHALL be independent: a full channel SHALL NOT block accepts to other channels.
REQ-022 oi SHALL hold its value while o_valid[i] is high and no pop occurs; when count[i]==0, oi is don't-care but SHALL NOT be X after reset.
REQ-023 acc_cnt SHALL increment by 1 per accept and wrap from 2^CNTW-1 to 0.
REQ-024 in_valid with in_ready low SHALL change no state.

Reset
REQ-025 On rst high at a rising edge: all counts 0, o_valid=4'b0000, o0..o3=0, acc_cnt=0, FIFO pointers 0.
REQ-026 Reset SHALL override a simultaneous accept or pop; in-flight words are discarded.
REQ-027 in_ready SHALL be 1 in the first cycle after reset.

Structure
REQ-028 The channel count (4), the select width (2), and the default W and CNTW constants SHALL live in the shared package/header demux_pkg.
REQ-029 The per-channel queue SHALL be a sub-module demux_fifo2 (W-wide, 2-deep, with push, pop, full, empty and head ports), instantiated 4 times.
REQ-030 The top level SHALL contain only select decode, the in_ready mux, and acc_cnt.

Verification
REQ-031 Reset: assert rst for 2 cycles with in_valid=1 -> o_valid=0000, o0..o3=0, acc_cnt=0, in_ready=1.
REQ-032 Routing: send d=6'h15 to s=2 with o_ready=0000 -> next cycle o_valid=0100, o2=6'h15, acc_cnt=1.
REQ-033 Backpressure: send 6'h01, 6'h02, 6'h03 to s=1 with o_ready=0000 -> third word stalls (in_ready=0 with s=1). Then raise o_ready[1] -> o1 shows 01, 02, 03 in order.
REQ-034 Independence: fill channel 0 to 2 entries, then send 6'h3F to s=3 -> accepted, o_valid=1001.
REQ-035 Simultaneous push/pop: channel 0 holds 1 entry (6'h0A), o_ready[0]=1, push 6'h0B to s=0 -> count stays 1, next o0=6'h0B.
REQ-036 Wrap and mid-operation reset: 256 accepts -> acc_cnt=0. Then assert rst while channels are non-empty -> all state is cleared per REQ-025.
